// File: rtl/load_store_unit.sv
// load_store_unit: drives data_memory, passing aligned accesses through and splitting misaligned ones into byte accesses.
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_stall,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_misaligned,
    output logic        o_size_err,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic [1:0]  o_mem_data_size,
    output logic        o_mem_data_unsigned,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);
    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_acc, r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned, r_we;
    logic        w_mis, w_last, w_accept;
    logic [4:0]  w_sh;
    assign w_mis    = (i_req_size == 2'b01 && i_req_addr[0]) || (i_req_size == 2'b10 && |i_req_addr[1:0]);
    assign w_last   = r_cnt == ((r_size == 2'b01) ? 2'd1 : 2'd3);
    assign w_sh     = {r_cnt, 3'b000};
    assign w_accept = r_state == IDLE && w_next == SPLIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_we       <= i_req_we;
                r_cnt      <= '0;
                r_acc      <= '0;
            end else if (r_state == SPLIT) begin
                if (!r_we) r_acc[w_sh +: 8] <= i_mem_rd[7:0];
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end
    // Status outputs stay low while reset is asserted, so an aborted split stops driving at once.
    always_comb begin
        w_next              = r_state;
        o_stall             = 1'b0;
        o_resp_valid        = 1'b0;
        o_resp_rdata        = '0;
        o_misaligned        = 1'b0;
        o_size_err          = 1'b0;
        o_mem_a             = i_req_addr;
        o_mem_wd            = i_req_wdata;
        o_mem_data_size     = i_req_size;
        o_mem_data_unsigned = i_req_unsigned;
        o_mem_we            = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                IDLE: if (i_req_valid) begin
                    if (i_req_size == 2'b11) o_size_err = 1'b1;
                    else if (w_mis && ALLOW_MISALIGNED) begin
                        o_stall = 1'b1;
                        w_next  = SPLIT;
                    end else if (w_mis) o_misaligned = 1'b1;
                    else begin
                        o_mem_we     = i_req_we;
                        o_resp_valid = !i_req_we;
                        o_resp_rdata = i_mem_rd;
                    end
                end
                SPLIT: begin
                    o_stall             = 1'b1;
                    o_mem_a             = r_addr + {30'b0, r_cnt};
                    o_mem_wd            = {24'b0, r_wdata[w_sh +: 8]};
                    o_mem_data_size     = 2'b00;
                    o_mem_data_unsigned = 1'b1;
                    o_mem_we            = r_we;
                    w_next              = w_last ? DONE : SPLIT;
                end
                DONE: begin
                    o_resp_valid = !r_we;
                    o_resp_rdata = r_we ? 32'b0 : (r_size == 2'b01) ? {{16{r_acc[15] & ~r_unsigned}}, r_acc[15:0]} : r_acc;
                    w_next       = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end
endmodule
